// File: rtl/master_clock_enable_gen.sv
// NES master-clock enable generator: CPU/PPU enables, M2 phase, reset stretch,
// run/pause/single-step debug control and a free-running CPU cycle counter.
module master_clock_enable_gen #(
    parameter int CPU_DIV  = 12,
    parameter int PPU_DIV  = 4,
    parameter int M2_HIGH  = 7,
    parameter int RST_HOLD = 64,
    parameter int CNT_W    = 32
) (
    input  logic             clk_mst,
    input  logic             rst,
    input  logic             run,
    input  logic             step_req,
    output logic             step_ack,
    output logic             sys_rst,
    output logic             cpu_ce,
    output logic             ppu_ce,
    output logic             m2,
    output logic [CNT_W-1:0] cpu_cycle
);

    if (CPU_DIV % PPU_DIV != 0) begin : g_bad_ppu_div
        $error("CPU_DIV must be a multiple of PPU_DIV");
    end
    if (M2_HIGH <= 0 || M2_HIGH >= CPU_DIV) begin : g_bad_m2_high
        $error("M2_HIGH must lie strictly between 0 and CPU_DIV");
    end
    if (RST_HOLD < 1) begin : g_bad_rst_hold
        $error("RST_HOLD must be at least 1");
    end

    localparam int PH_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam int HW   = $clog2(RST_HOLD + 1);

    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CPU_DIV - 1);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [31:0]     M2_START  = 32'(CPU_DIV - M2_HIGH);
    localparam logic [31:0]     PPU_MOD   = 32'(PPU_DIV);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_PAUSED,
        S_STEP
    } state_t;

    state_t          state;
    logic [PH_W-1:0] phase;
    logic [HW-1:0]   hold;
    logic [PH_W-1:0] phase_nx;
    logic            phase_last;
    logic            adv;

    assign phase_last = (phase == PH_LAST);
    assign phase_nx   = phase_last ? '0 : phase + PH_W'(1);

    // Outputs decode from registered state only; inputs never reach them
    // combinationally.
    assign adv     = (state == S_RUN) || (state == S_STEP);
    assign sys_rst = (state == S_HOLD);
    assign cpu_ce  = adv && (phase == '0);
    assign ppu_ce  = adv && ((32'(phase) % PPU_MOD) == 32'd0);
    assign m2      = adv && (32'(phase) >= M2_START);

    always_ff @(posedge clk_mst) begin
        if (rst) begin
            state     <= S_HOLD;
            hold      <= '0;
            phase     <= '0;
            cpu_cycle <= '0;
            step_ack  <= 1'b0;
        end else begin
            step_ack <= 1'b0;
            if (cpu_ce) begin
                cpu_cycle <= cpu_cycle + CNT_W'(1);
            end
            unique case (state)
                S_HOLD: begin
                    phase <= '0;
                    if (hold == HOLD_LAST) begin
                        state <= run ? S_RUN : S_PAUSED;
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                S_RUN: begin
                    phase <= phase_nx;
                    if (phase_last && !run) begin
                        state <= S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    phase <= '0;
                    if (run) begin
                        state <= S_RUN;
                    end else if (step_req) begin
                        state <= S_STEP;
                    end
                end
                S_STEP: begin
                    // A step always completes a whole CPU cycle.
                    phase <= phase_nx;
                    if (phase_last) begin
                        step_ack <= 1'b1;
                        state    <= run ? S_RUN : S_PAUSED;
                    end
                end
                default: begin
                    state <= S_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_master_clock_enable_gen.sv
// Bench for master_clock_enable_gen: segment table, random run/step/rst
// traffic against a cycle-schedule model, and a narrow-counter wrap check.
module tb_master_clock_enable_gen;

    localparam int CPU_DIV  = 12;
    localparam int PPU_DIV  = 4;
    localparam int M2_HIGH  = 7;
    localparam int RST_HOLD = 64;

    logic clk_mst = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic step_req = 1'b0;

    logic        step_ack, sys_rst, cpu_ce, ppu_ce, m2;
    logic [31:0] cpu_cycle;
    logic        step_ack4, sys_rst4, cpu_ce4, ppu_ce4, m2_4;
    logic [3:0]  cpu_cycle4;

    int n_checks = 0;
    int n_errors = 0;

    // Model: remaining reset-stretch cycles, and whether a CPU cycle is in
    // progress (offset into it, and whether it was started by a step).
    int          m_hold = 0;
    bit          m_active = 1'b0;
    bit          m_step = 1'b0;
    int          m_off = 0;
    bit          m_ack = 1'b0;
    int unsigned m_cnt = 0;

    int c_cpu, c_ppu, c_m2, c_ack, c_srst;

    always #5 clk_mst = ~clk_mst;

    master_clock_enable_gen dut (
        .clk_mst  (clk_mst),
        .rst      (rst),
        .run      (run),
        .step_req (step_req),
        .step_ack (step_ack),
        .sys_rst  (sys_rst),
        .cpu_ce   (cpu_ce),
        .ppu_ce   (ppu_ce),
        .m2       (m2),
        .cpu_cycle(cpu_cycle)
    );

    master_clock_enable_gen #(.CNT_W(4)) dut4 (
        .clk_mst  (clk_mst),
        .rst      (rst),
        .run      (run),
        .step_req (step_req),
        .step_ack (step_ack4),
        .sys_rst  (sys_rst4),
        .cpu_ce   (cpu_ce4),
        .ppu_ce   (ppu_ce4),
        .m2       (m2_4),
        .cpu_cycle(cpu_cycle4)
    );

    typedef struct {
        int r;
        int ru;
        int sr;
        int n;
        int cpu;
        int ppu;
        int m2v;
        int ack;
        int srst;
        int cyc;
    } seg_t;

    seg_t segs[17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic void model_edge(bit r, bit ru, bit sr);
        if (r) begin
            m_hold   = RST_HOLD;
            m_active = 1'b0;
            m_step   = 1'b0;
            m_off    = 0;
            m_ack    = 1'b0;
            m_cnt    = 0;
        end else begin
            m_ack = 1'b0;
            if (m_active && m_off == 0) m_cnt++;
            if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) begin
                    m_active = ru;
                    m_step   = 1'b0;
                    m_off    = 0;
                end
            end else if (m_active) begin
                if (m_off == CPU_DIV - 1) begin
                    if (m_step) m_ack = 1'b1;
                    m_active = ru;
                    m_step   = 1'b0;
                    m_off    = 0;
                end else begin
                    m_off++;
                end
            end else if (ru) begin
                m_active = 1'b1;
                m_step   = 1'b0;
                m_off    = 0;
            end else if (sr) begin
                m_active = 1'b1;
                m_step   = 1'b1;
                m_off    = 0;
            end
        end
    endfunction

    task automatic check_model();
        logic e_srst, e_cpu, e_ppu, e_m2;
        e_srst = (m_hold > 0);
        e_cpu  = m_active && (m_off == 0);
        e_ppu  = m_active && (m_off % PPU_DIV == 0);
        e_m2   = m_active && (m_off >= CPU_DIV - M2_HIGH);
        chk("sys_rst", 32'(sys_rst), 32'(e_srst));
        chk("cpu_ce", 32'(cpu_ce), 32'(e_cpu));
        chk("ppu_ce", 32'(ppu_ce), 32'(e_ppu));
        chk("m2", 32'(m2), 32'(e_m2));
        chk("step_ack", 32'(step_ack), 32'(m_ack));
        chk("cpu_cycle", cpu_cycle, m_cnt);
        chk("sys_rst4", 32'(sys_rst4), 32'(e_srst));
        chk("cpu_ce4", 32'(cpu_ce4), 32'(e_cpu));
        chk("ppu_ce4", 32'(ppu_ce4), 32'(e_ppu));
        chk("m2_4", 32'(m2_4), 32'(e_m2));
        chk("step_ack4", 32'(step_ack4), 32'(m_ack));
        chk("cpu_cycle4", 32'(cpu_cycle4), m_cnt & 32'hF);
    endtask

    task automatic tick(input int r, input int ru, input int sr);
        rst      = (r != 0);
        run      = (ru != 0);
        step_req = (sr != 0);
        @(posedge clk_mst);
        model_edge(r != 0, ru != 0, sr != 0);
        #1;
        check_model();
        if (cpu_ce === 1'b1) c_cpu++;
        if (ppu_ce === 1'b1) c_ppu++;
        if (m2 === 1'b1) c_m2++;
        if (step_ack === 1'b1) c_ack++;
        if (sys_rst === 1'b1) c_srst++;
    endtask

    initial begin
        bit run_lvl;

        // r ru sr n | cpu ppu m2 ack srst | cpu_cycle at segment end
        segs[0]  = '{1, 0, 0,  3, 0, 0,  0, 0,  3, 0};
        segs[1]  = '{0, 1, 0, 63, 0, 0,  0, 0, 63, 0};
        segs[2]  = '{0, 1, 0, 24, 2, 6, 14, 0,  0, 2};
        segs[3]  = '{0, 1, 0,  3, 1, 1,  0, 0,  0, 3};
        segs[4]  = '{0, 0, 0, 12, 0, 2,  7, 0,  0, 3};
        segs[5]  = '{0, 0, 0, 10, 0, 0,  0, 0,  0, 3};
        segs[6]  = '{0, 0, 1,  1, 1, 1,  0, 0,  0, 3};
        segs[7]  = '{0, 0, 0, 12, 0, 2,  7, 1,  0, 4};
        segs[8]  = '{0, 0, 0,  5, 0, 0,  0, 0,  0, 4};
        segs[9]  = '{0, 1, 1,  1, 1, 1,  0, 0,  0, 4};
        segs[10] = '{0, 1, 0, 23, 1, 5, 14, 0,  0, 6};
        segs[11] = '{0, 0, 0,  4, 0, 0,  0, 0,  0, 6};
        segs[12] = '{0, 0, 1,  1, 1, 1,  0, 0,  0, 6};
        segs[13] = '{0, 0, 0,  6, 0, 1,  2, 0,  0, 7};
        segs[14] = '{1, 0, 0,  1, 0, 0,  0, 0,  1, 0};
        segs[15] = '{0, 0, 0, 63, 0, 0,  0, 0, 63, 0};
        segs[16] = '{0, 0, 0, 10, 0, 0,  0, 0,  0, 0};

        for (int s = 0; s < 17; s++) begin
            c_cpu = 0; c_ppu = 0; c_m2 = 0; c_ack = 0; c_srst = 0;
            for (int k = 0; k < segs[s].n; k++) begin
                tick(segs[s].r, segs[s].ru, segs[s].sr);
            end
            chk($sformatf("seg%0d cpu_ce count", s), c_cpu, segs[s].cpu);
            chk($sformatf("seg%0d ppu_ce count", s), c_ppu, segs[s].ppu);
            chk($sformatf("seg%0d m2 count", s), c_m2, segs[s].m2v);
            chk($sformatf("seg%0d step_ack count", s), c_ack, segs[s].ack);
            chk($sformatf("seg%0d sys_rst count", s), c_srst, segs[s].srst);
            chk($sformatf("seg%0d cpu_cycle", s), cpu_cycle, segs[s].cyc);
            chk($sformatf("seg%0d cpu_cycle4", s), 32'(cpu_cycle4),
                segs[s].cyc);
        end

        run_lvl = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) run_lvl = ~run_lvl;
            tick(($urandom_range(0, 299) == 0) ? 1 : 0, int'(run_lvl),
                 ($urandom_range(0, 7) == 0) ? 1 : 0);
        end

        // Narrow counter: the 16th cpu_ce wraps 15 -> 0.
        tick(1, 1, 0);
        repeat (63) tick(0, 1, 0);
        repeat (180) tick(0, 1, 0);
        tick(0, 1, 0);
        chk("wrap cpu_ce at 16th pulse", 32'(cpu_ce4), 32'd1);
        chk("wrap cpu_cycle4 before", 32'(cpu_cycle4), 32'd15);
        tick(0, 1, 0);
        chk("wrap cpu_cycle4 after", 32'(cpu_cycle4), 32'd0);
        chk("wrap cpu_cycle wide", cpu_cycle, 32'd16);
        repeat (30) tick(0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
